acondicionador_entradas: RTL

ACONDICIONADOR_ENTRADAS -- requirements
Module: acondicionador_entradas

---
 rtl/entradas_pkg.sv | 21 ++
 rtl/acondicionador_entradas_antirrebote.sv | 80 ++++++++
 rtl/acondicionador_entradas.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/entradas_pkg.sv
// rtl/entradas_pkg.sv - shared debounce FSM encoding, default timings and width helper
package entradas_pkg;

  typedef enum logic [1:0] {
    BAJO        = 2'd0,
    ESPERA_ALTO = 2'd1,
    ALTO        = 2'd2,
    ESPERA_BAJO = 2'd3
  } estado_t;

  // Defaults assume a 100 MHz clock: 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int REPEAT_DELAY_DEF    = 50_000_000;
  localparam int REPEAT_PERIOD_DEF   = 10_000_000;

  // Counter width for a count of n cycles; never narrower than one bit
  function automatic int ancho(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acondicionador_entradas_antirrebote.sv
// rtl/acondicionador_entradas_antirrebote.sv - per-channel 2-flop synchronizer and debounce FSM
module antirrebote
  import entradas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_nivel,
  output logic o_nivel_sig
);

  localparam int CW = ancho(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  estado_t       r_estado;
  estado_t       w_estado_sig;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_sig;
  logic          w_in;

  assign w_in = r_sync[1];

  // Two-flop synchronizer for the raw asynchronous input
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[0], i_raw};
  end

  // State and stability counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_estado <= BAJO;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_cnt    <= w_cnt_sig;
    end
  end

  // Next state: the counter stops at C_MAX because reaching it always leaves the waiting state
  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = r_cnt;
    case (r_estado)
      BAJO: begin
        if (w_in) begin
          w_estado_sig = ESPERA_ALTO;
          w_cnt_sig    = '0;
        end
      end
      ESPERA_ALTO: begin
        if (!w_in)               w_estado_sig = BAJO;
        else if (r_cnt == C_MAX) w_estado_sig = ALTO;
        else                     w_cnt_sig    = r_cnt + 1'b1;
      end
      ALTO: begin
        if (!w_in) begin
          w_estado_sig = ESPERA_BAJO;
          w_cnt_sig    = '0;
        end
      end
      ESPERA_BAJO: begin
        if (w_in)                w_estado_sig = ALTO;
        else if (r_cnt == C_MAX) w_estado_sig = BAJO;
        else                     w_cnt_sig    = r_cnt + 1'b1;
      end
      default: w_estado_sig = BAJO;
    endcase
  end

  // Debounced level now and after the coming edge, so the top can register edges without extra delay
  always_comb begin
    o_nivel     = (r_estado == ALTO) || (r_estado == ESPERA_BAJO);
    o_nivel_sig = (w_estado_sig == ALTO) || (w_estado_sig == ESPERA_BAJO);
  end

endmodule

// File: rtl/acondicionador_entradas.sv
// rtl/acondicionador_entradas.sv - debounced buttons with press/auto-repeat pulses and filtered mode switches
module acondicionador_entradas
  import entradas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_arriba,
  input  logic i_btn_abajo,
  input  logic i_btn_izquierda,
  input  logic i_btn_derecha,
  input  logic i_sw_escribe,
  input  logic i_sw_crono,
  input  logic i_sw_reset,
  input  logic i_sw_cr_activo,
  output logic o_push_arriba,
  output logic o_push_abajo,
  output logic o_push_izquierda,
  output logic o_push_derecha,
  output logic o_escribe1,
  output logic o_crono1,
  output logic o_reset1,
  output logic o_cr_activo1,
  output logic o_conflicto
);

  localparam int RW = ancho((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD - 1);

  // Channel order: 0 arriba, 1 abajo, 2 izquierda, 3 derecha, 4 escribe, 5 crono, 6 reset, 7 cr_activo
  logic [7:0]    w_raw;
  logic [3:0]    w_nivel;
  logic [3:0]    w_unused_nivel;
  logic [7:0]    w_nivel_sig;
  logic [3:0]    w_sube;
  logic [1:0]    w_rep;
  logic [3:0]    w_pulso;
  logic          w_conf;
  logic [RW-1:0] r_rep_cnt [2];
  logic [1:0]    r_rep_fase;
  logic [3:0]    r_push;
  logic          r_escribe1;
  logic          r_crono1;
  logic          r_reset1;
  logic          r_cr_activo1;
  logic          r_conflicto;

  assign w_raw = {i_sw_cr_activo, i_sw_reset, i_sw_crono, i_sw_escribe,
                  i_btn_derecha, i_btn_izquierda, i_btn_abajo, i_btn_arriba};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_raw       (w_raw[g]),
      .o_nivel     (w_nivel[g]),
      .o_nivel_sig (w_nivel_sig[g])
    );
  end

  for (genvar g = 4; g < 8; g++) begin : g_sw
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_raw       (w_raw[g]),
      .o_nivel     (w_unused_nivel[g-4]),
      .o_nivel_sig (w_nivel_sig[g])
    );
  end

  // Press/repeat candidates and mode-switch conflict detection
  always_comb begin
    w_sube = w_nivel_sig[3:0] & ~w_nivel;
    for (int k = 0; k < 2; k++) begin
      w_rep[k] = w_nivel[k] && w_nivel_sig[k] &&
                 (r_rep_cnt[k] == (r_rep_fase[k] ? R_PERIOD : R_DELAY));
    end
    w_pulso = {w_sube[3], w_sube[2], w_sube[1] | w_rep[1], w_sube[0] | w_rep[0]};
    w_conf  = (w_nivel_sig[4] & w_nivel_sig[5]) |
              (w_nivel_sig[4] & w_nivel_sig[7]) |
              (w_nivel_sig[5] & w_nivel_sig[7]);
  end

  // Auto-repeat timers for arriba/abajo: restart on press, cleared as soon as the level drops
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < 2; k++) r_rep_cnt[k] <= '0;
      r_rep_fase <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_sube[k] || !w_nivel_sig[k]) begin
          r_rep_cnt[k]  <= '0;
          r_rep_fase[k] <= 1'b0;
        end else if (w_rep[k]) begin
          r_rep_cnt[k]  <= '0;
          r_rep_fase[k] <= 1'b1;
        end else if (r_rep_cnt[k] != '1) begin
          r_rep_cnt[k]  <= r_rep_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Registered pulses; a coincident pulse on the opposite direction cancels both
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_push <= '0;
    end else begin
      r_push[0] <= w_pulso[0] & ~w_pulso[1];
      r_push[1] <= w_pulso[1] & ~w_pulso[0];
      r_push[2] <= w_pulso[2] & ~w_pulso[3];
      r_push[3] <= w_pulso[3] & ~w_pulso[2];
    end
  end

  // Registered switch levels; mode switches are blanked while more than one is on
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_escribe1   <= 1'b0;
      r_crono1     <= 1'b0;
      r_reset1     <= 1'b0;
      r_cr_activo1 <= 1'b0;
      r_conflicto  <= 1'b0;
    end else begin
      r_escribe1   <= w_nivel_sig[4] & ~w_conf;
      r_crono1     <= w_nivel_sig[5] & ~w_conf;
      r_reset1     <= w_nivel_sig[6];
      r_cr_activo1 <= w_nivel_sig[7] & ~w_conf;
      r_conflicto  <= w_conf;
    end
  end

  assign o_push_arriba    = r_push[0];
  assign o_push_abajo     = r_push[1];
  assign o_push_izquierda = r_push[2];
  assign o_push_derecha   = r_push[3];
  assign o_escribe1       = r_escribe1;
  assign o_crono1         = r_crono1;
  assign o_reset1         = r_reset1;
  assign o_cr_activo1     = r_cr_activo1;
  assign o_conflicto      = r_conflicto;

endmodule
